// File: rtl/alu_console_seq.sv
// alu_console_seq - sequential operator console for the board ALU.
//
// Operands A and B are entered from the switches CHUNK_W bits at a time. Each
// debounced Enter press shifts one chunk into the active operand. The op code
// is entered next, and the ALU result and flags are captured one cycle later.
// The active value is shown live on the 7-segment digits.
//
// Ports
//   CLOCK_50     in   single clock, rising edge
//   reset        in   synchronous, active-high
//   sw           in   raw switch data (CHUNK_W bits)
//   key_enter_n  in   raw Enter button, active-low, asynchronous
//   key_back_n   in   raw Back button, active-low, asynchronous
//   alu_y        in   ALU result (combinational from alu_a/alu_b/alu_op)
//   alu_flags    in   ALU raw flags
//   alu_a/alu_b  out  registered operands to the ALU
//   alu_op       out  registered op code to the ALU
//   result       out  captured ALU result
//   flags        out  captured ALU flags
//   state_oh     out  one-hot state {SHOW,EXEC,OP,B,A}
//   hex          out  active-low segments, digit 0 in bits [6:0]

// Hex nibble to active-low 7-segment pattern (bit 6 = segment g).
module hex7seg (
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = 7'b1111111;
    case (i_nib)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'b1111111;
    endcase
  end
endmodule

// Button conditioner: 2-flop synchronizer followed by a debounce counter.
// o_press is a one-cycle pulse on an accepted 1->0 transition only.
module alu_console_deb #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic             r_sync_p0;
  logic             r_sync_p1;
  logic             r_level;
  logic [DEB_W-1:0] r_cnt;
  logic             r_press;
  logic             w_diff;
  logic             w_hit;

  assign w_diff = (r_sync_p1 != r_level);
  // The count has to have reached DEB_CYCLES while the mismatch persists.
  assign w_hit  = w_diff && (r_cnt == DEB_W'(DEB_CYCLES));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
      r_level   <= 1'b1;
      r_cnt     <= '0;
      r_press   <= 1'b0;
    end else begin
      r_sync_p0 <= i_key_n;
      r_sync_p1 <= r_sync_p0;
      r_press   <= w_hit && !r_sync_p1;
      if (w_hit) begin
        r_level <= r_sync_p1;
        r_cnt   <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + DEB_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;
endmodule

module alu_console_seq #(
  parameter int DATA_W     = 16,
  parameter int CHUNK_W    = 8,
  parameter int OP_W       = 5,
  parameter int DEB_CYCLES = 500000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [CHUNK_W-1:0]      sw,
  input  logic                    key_enter_n,
  input  logic                    key_back_n,
  input  logic [DATA_W-1:0]       alu_y,
  input  logic [4:0]              alu_flags,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  output logic [OP_W-1:0]         alu_op,
  output logic [DATA_W-1:0]       result,
  output logic [4:0]              flags,
  output logic [4:0]              state_oh,
  output logic [7*(DATA_W/4)-1:0] hex
);
  localparam int NCH   = DATA_W / CHUNK_W;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NDIG  = DATA_W / 4;

  // One-hot encoding so the state register drives state_oh directly.
  typedef enum logic [4:0] {
    S_A    = 5'b00001,
    S_B    = 5'b00010,
    S_OP   = 5'b00100,
    S_EXEC = 5'b01000,
    S_SHOW = 5'b10000
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_result;
  logic [4:0]        r_flags;

  logic              w_enter_p;
  logic              w_back_p;
  logic              w_last;
  logic              w_shift_a;
  logic              w_shift_b;
  logic              w_load_op;
  logic              w_capture;
  logic              w_clear;
  logic              w_cnt_inc;
  logic              w_cnt_clr;
  logic [DATA_W-1:0] w_disp;

  alu_console_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .i_clk   (CLOCK_50),
    .i_rst   (reset),
    .i_key_n (key_enter_n),
    .o_press (w_enter_p)
  );

  alu_console_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_back (
    .i_clk   (CLOCK_50),
    .i_rst   (reset),
    .i_key_n (key_back_n),
    .o_press (w_back_p)
  );

  assign w_last = (r_cnt == CNT_W'(NCH - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= S_A;
    else       r_state <= w_next;
  end

  // Back is tested before Enter everywhere, so a simultaneous Enter is lost.
  always_comb begin
    w_next    = r_state;
    w_shift_a = 1'b0;
    w_shift_b = 1'b0;
    w_load_op = 1'b0;
    w_capture = 1'b0;
    w_clear   = 1'b0;
    w_cnt_inc = 1'b0;
    w_cnt_clr = 1'b0;
    unique case (r_state)
      S_A: begin
        if (w_back_p) begin
          w_clear = 1'b1;
          w_next  = S_A;
        end else if (w_enter_p) begin
          w_shift_a = 1'b1;
          if (w_last) begin
            w_cnt_clr = 1'b1;
            w_next    = S_B;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_B: begin
        if (w_back_p) begin
          w_clear = 1'b1;
          w_next  = S_A;
        end else if (w_enter_p) begin
          w_shift_b = 1'b1;
          if (w_last) begin
            w_cnt_clr = 1'b1;
            w_next    = S_OP;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_OP: begin
        if (w_back_p) begin
          w_clear = 1'b1;
          w_next  = S_A;
        end else if (w_enter_p) begin
          w_load_op = 1'b1;
          w_next    = S_EXEC;
        end
      end
      // Single cycle; any button pulse landing here is dropped.
      S_EXEC: begin
        w_capture = 1'b1;
        w_next    = S_SHOW;
      end
      S_SHOW: begin
        if (w_back_p) begin
          w_next = S_OP;
        end else if (w_enter_p) begin
          w_clear = 1'b1;
          w_next  = S_A;
        end
      end
      default: begin
        w_clear = 1'b1;
        w_next  = S_A;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      if (w_clear) begin
        r_a   <= '0;
        r_b   <= '0;
        r_op  <= '0;
        r_cnt <= '0;
      end else begin
        // New chunk enters at the bottom; the oldest chunk falls off the top.
        if (w_shift_a) r_a <= DATA_W'({r_a, sw});
        if (w_shift_b) r_b <= DATA_W'({r_b, sw});
        if (w_load_op) r_op <= sw[OP_W-1:0];
        if (w_cnt_clr)      r_cnt <= '0;
        else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_capture) begin
        r_result <= alu_y;
        r_flags  <= alu_flags;
      end
    end
  end

  assign alu_a    = r_a;
  assign alu_b    = r_b;
  assign alu_op   = r_op;
  assign result   = r_result;
  assign flags    = r_flags;
  assign state_oh = r_state;

  always_comb begin
    w_disp = r_result;
    unique case (r_state)
      S_A:     w_disp = r_a;
      S_B:     w_disp = r_b;
      S_OP:    w_disp = {{(DATA_W-OP_W){1'b0}}, r_op};
      default: w_disp = r_result;
    endcase
  end

  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    hex7seg u_seg (
      .i_nib (w_disp[4*g +: 4]),
      .o_seg (hex[7*g +: 7])
    );
  end
endmodule

// File: tb/tb_alu_console_seq.sv
module tb_alu_console_seq;
  localparam int DATA_W  = 16;
  localparam int CHUNK_W = 8;
  localparam int OP_W    = 5;
  localparam int DEB     = 4;

  localparam logic [4:0] ST_A    = 5'b00001;
  localparam logic [4:0] ST_B    = 5'b00010;
  localparam logic [4:0] ST_OP   = 5'b00100;
  localparam logic [4:0] ST_EXEC = 5'b01000;
  localparam logic [4:0] ST_SHOW = 5'b10000;

  logic              clk = 1'b0;
  logic              reset;
  logic [CHUNK_W-1:0] sw;
  logic              ke_n;
  logic              kb_n;
  logic [DATA_W-1:0] alu_y;
  logic [4:0]        alu_flags;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] result;
  logic [4:0]        flags;
  logic [4:0]        state_oh;
  logic [27:0]       hex;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [6:0] seg_tab [16];

  always #5 clk = ~clk;

  alu_console_seq #(
    .DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .OP_W(OP_W), .DEB_CYCLES(DEB)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .sw          (sw),
    .key_enter_n (ke_n),
    .key_back_n  (kb_n),
    .alu_y       (alu_y),
    .alu_flags   (alu_flags),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .result      (result),
    .flags       (flags),
    .state_oh    (state_oh),
    .hex         (hex)
  );

  // Environment ALU: op 0 adds, op 8 subtracts, everything else XORs.
  function automatic logic [15:0] ref_alu(logic [15:0] a, logic [15:0] b, logic [4:0] op);
    int unsigned s;
    if (op == 5'd0)      s = (int'(a) + int'(b)) % 65536;
    else if (op == 5'd8) s = (int'(a) - int'(b) + 65536) % 65536;
    else                 s = int'(a ^ b);
    return s[15:0];
  endfunction

  function automatic logic [4:0] ref_flags(logic [15:0] y);
    return {(y == 16'h0), y[15], y[0], 2'b10};
  endfunction

  assign alu_y     = ref_alu(alu_a, alu_b, alu_op);
  assign alu_flags = ref_flags(alu_y);

  function automatic logic [27:0] exp_hex(logic [15:0] v);
    logic [27:0] h;
    for (int d = 0; d < 4; d++) h[7*d +: 7] = seg_tab[(v >> (4*d)) & 16'hF];
    return h;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(bit en, bit bk, int hold);
    if (en) ke_n = 1'b0;
    if (bk) kb_n = 1'b0;
    tick(hold);
    ke_n = 1'b1;
    kb_n = 1'b1;
    tick(14);
  endtask

  task automatic enter_chunk(logic [7:0] v);
    sw = v;
    press(1'b1, 1'b0, 10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ke_n  = 1'b1;
    kb_n  = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  // Enter press that records when EXEC is seen and for how many samples.
  task automatic op_press_watch(logic [7:0] op, output int first, output int n_exec);
    first  = -1;
    n_exec = 0;
    sw     = op;
    ke_n   = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 10) ke_n = 1'b1;
      if (state_oh == ST_EXEC) begin
        n_exec++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    int first, n_exec, found;
    logic [7:0]  c0, c1, c2, c3;
    logic [4:0]  op;
    logic [15:0] ma, mb, my;

    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    sw = '0;

    // Reset state
    do_reset();
    check("rst_state", state_oh, ST_A);
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_hex", hex, {4{7'b1000000}});

    // Latency and long hold: the pulse rises 2+DEB edges after the first low
    // sample (edge 0); the shift lands one edge later, seen at the next negedge.
    sw   = 8'h5A;
    ke_n = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 2 + DEB + 1) check("lat_before", alu_a, 16'h0000);
      if (i == 2 + DEB + 2) check("lat_shift", alu_a, 16'h005A);
    end
    ke_n = 1'b1;
    tick(15);
    check("hold_one_shift", alu_a, 16'h005A);
    check("hold_state", state_oh, ST_A);
    check("hold_hex_live", hex, exp_hex(16'h005A));

    enter_chunk(8'h3C);
    check("a_done", alu_a, 16'h5A3C);
    check("a_done_state", state_oh, ST_B);

    // Bounce shorter than DEB never yields a pulse
    for (int i = 0; i < 40; i++) begin
      ke_n = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    ke_n = 1'b1;
    tick(15);
    check("bounce_b", alu_b, 16'h0000);
    check("bounce_a", alu_a, 16'h5A3C);
    check("bounce_state", state_oh, ST_B);

    // Back and Enter together in S_B after one chunk: back wins
    enter_chunk(8'h77);
    check("b_partial", alu_b, 16'h0077);
    sw = 8'h99;
    press(1'b1, 1'b1, 10);
    check("prio_state", state_oh, ST_A);
    check("prio_a", alu_a, 0);
    check("prio_b", alu_b, 0);

    // Full operation: 0x1234 - 0x0010
    enter_chunk(8'h12);
    check("full_a_partial", alu_a, 16'h0012);
    enter_chunk(8'h34);
    enter_chunk(8'h00);
    enter_chunk(8'h10);
    check("full_a", alu_a, 16'h1234);
    check("full_b", alu_b, 16'h0010);
    check("full_state_op", state_oh, ST_OP);
    op_press_watch(8'h08, first, n_exec);
    check("exec_first", first, 2 + DEB + 2);
    check("exec_len", n_exec, 1);
    check("full_result", result, 16'h1224);
    check("full_flags", flags, ref_flags(16'h1224));
    check("full_state", state_oh, ST_SHOW);
    check("full_op", alu_op, 5'd8);
    check("full_hex", hex, exp_hex(16'h1224));

    // Back in SHOW: rerun with a new op on the same operands
    press(1'b0, 1'b1, 10);
    check("rerun_state", state_oh, ST_OP);
    check("rerun_a", alu_a, 16'h1234);
    check("rerun_b", alu_b, 16'h0010);
    check("rerun_hex_op", hex, exp_hex(16'h0008));
    check("rerun_held", result, 16'h1224);
    enter_chunk(8'h00);
    check("rerun_result", result, 16'h1244);
    check("rerun_show", state_oh, ST_SHOW);

    // Enter in SHOW clears and restarts
    enter_chunk(8'hFF);
    check("show_enter_state", state_oh, ST_A);
    check("show_enter_a", alu_a, 0);
    check("show_enter_b", alu_b, 0);
    check("show_enter_op", alu_op, 0);
    check("show_enter_res", result, 16'h1244);

    // Abort in S_OP keeps result
    enter_chunk(8'h01);
    enter_chunk(8'h02);
    enter_chunk(8'h03);
    enter_chunk(8'h04);
    press(1'b0, 1'b1, 10);
    check("abort_state", state_oh, ST_A);
    check("abort_a", alu_a, 0);
    check("abort_b", alu_b, 0);
    check("abort_result", result, 16'h1244);

    // Reset during EXEC discards the pending capture
    do_reset();
    enter_chunk(8'hAB);
    enter_chunk(8'hCD);
    enter_chunk(8'h00);
    enter_chunk(8'h01);
    found = 0;
    sw    = 8'h08;
    ke_n  = 1'b0;
    for (int i = 1; i <= 30 && found == 0; i++) begin
      @(negedge clk);
      if (state_oh == ST_EXEC) begin
        found = 1;
        reset = 1'b1;
      end
    end
    check("rst_exec_seen", found, 1);
    ke_n = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(12);
    check("rst_exec_result", result, 0);
    check("rst_exec_state", state_oh, ST_A);
    check("rst_exec_a", alu_a, 0);

    // Randomized operations against the reference model
    for (int t = 0; t < 5; t++) begin
      c0 = 8'($urandom);
      c1 = 8'($urandom);
      c2 = 8'($urandom);
      c3 = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       op = 5'd0;
        1:       op = 5'd8;
        default: op = 5'($urandom_range(0, 31));
      endcase
      ma = 16'(int'(c0) * 256 + int'(c1));
      mb = 16'(int'(c2) * 256 + int'(c3));
      my = ref_alu(ma, mb, op);
      enter_chunk(c0);
      enter_chunk(c1);
      enter_chunk(c2);
      enter_chunk(c3);
      check("rnd_a", alu_a, ma);
      check("rnd_b", alu_b, mb);
      enter_chunk({3'b000, op});
      check("rnd_result", result, my);
      check("rnd_flags", flags, ref_flags(my));
      check("rnd_hex", hex, exp_hex(my));
      check("rnd_state", state_oh, ST_SHOW);
      enter_chunk(8'h00);
      check("rnd_restart", state_oh, ST_A);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_console_seq.md
# alu_console_seq

Sequential operator console for the 16-bit ALU on the DE-series board. It accepts operands A and B and an op code entered from the switches in CHUNK_W-bit pieces, using debounced push-buttons. It drives the ALU operand/op inputs, captures the ALU result and flags into registers, and shows the active value on 7-segment digits through hex7seg instances. It replaces the fixed 4-bit, switch-wired ALU demo with a parametrised, stateful front end.

## Interface
- DATA_W, 16: operand/result width; multiple of 4 and of CHUNK_W.
- CHUNK_W, 8: switch bits loaded per Enter press; must be ≥ OP_W.
- OP_W, 5: ALU op code width.
- DEB_CYCLES, 500000: stable cycles required to accept a button level; ≥ 2.
- CLOCK_50  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; this is fixed.
- sw  in  CHUNK_W  raw switch data.
- key_enter_n  in  1  raw Enter button, active-low, asynchronous.
- key_back_n  in  1  raw Back button, active-low, asynchronous.
- alu_y  in  DATA_W  ALU result (combinational from alu_a/alu_b/alu_op).
- alu_flags  in  5  ALU raw flags.
- alu_a, alu_b  out  DATA_W  registered operands to ALU.
- alu_op  out  OP_W  registered op code to ALU.
- result  out  DATA_W  captured ALU result.
- flags  out  5  captured ALU flags.
- state_oh  out  5  one-hot state {SHOW,EXEC,OP,B,A} (bit0 = A).
- hex  out  7*(DATA_W/4)  active-low segments, digit 0 in bits [6:0].

## Operation
- Each key passes through a 2-flop synchronizer (reset value 1), then a debounce counter.
  - The counter increments while the synchronized level differs from the accepted level, and clears otherwise.
  - When the count reaches DEB_CYCLES, the accepted level takes the synchronized value.
  - A 1→0 acceptance produces a one-cycle press pulse (enter_p / back_p). Release produces no pulse.
- Chunk counter cnt runs 0..DATA_W/CHUNK_W−1.
- FSM states:
  - S_A: enter_p does a_reg ← {a_reg[DATA_W−CHUNK_W−1:0], sw} and cnt++. On the enter_p with cnt = last, shift, clear cnt, go to S_B.
  - S_B: same as S_A on b_reg; the last chunk goes to S_OP.
  - S_OP: enter_p does op_reg ← sw[OP_W−1:0] and goes to S_EXEC.
  - S_EXEC: exactly one cycle. result ← alu_y, flags ← alu_flags, go to S_SHOW. Presses in this cycle are ignored.
  - S_SHOW: enter_p clears a_reg, b_reg, op_reg and cnt, and goes to S_A. back_p goes to S_OP, keeping A and B, so the same operands can rerun with a new op.
- back_p in S_A, S_B or S_OP aborts: it clears a_reg, b_reg, op_reg and cnt, and goes to S_A. result and flags are held.
- If enter_p and back_p occur in the same cycle, back_p wins and enter is discarded.
- alu_a = a_reg, alu_b = b_reg, alu_op = op_reg, all driven directly from registers.
- Display source per state: S_A shows a_reg; S_B shows b_reg; S_OP shows op_reg zero-extended; S_EXEC and S_SHOW show result. Each nibble goes through a hex7seg instance.
- Partial operand entry is visible live: digits show the shifted register contents.

## Timing
- Reset (synchronous, checked every edge) sets:
  - state S_A (state_oh = 5'b00001)
  - all data registers, result, flags and cnt to 0
  - synchronizers and accepted levels to 1, counters to 0, no pulses
  - hex = all digits showing "0" (7'b1000000 each)
- Reset mid-entry or in S_EXEC discards everything, including a pending capture.
- Press latency: a raw 1→0 held steady produces enter_p exactly 2 + DEB_CYCLES cycles after the first low-sampled edge. The register update lands on the following edge.
- A bounce shorter than DEB_CYCLES cycles never produces a pulse. Any level mismatch gap restarts the count.
- Holding a button produces one pulse only. A new pulse requires an accepted release first.
- result and flags update exactly 1 cycle after the op_reg load (the S_EXEC cycle) and hold until the next S_EXEC.
- No wrap-around within a state: cnt clears on the state exit.
- Pulses arriving in S_EXEC are dropped, not queued.

## Test plan
All scenarios use DATA_W=16, CHUNK_W=8, DEB_CYCLES=4.
- Reset: hold reset 3 cycles → state_oh=00001; alu_a, alu_b, result = 0; all four hex digits = 7'b1000000.
- Full op: Enter sw=0x12, 0x34 (A=0x1234), then 0x00, 0x10 (B=0x0010), then op=8. Model ALU as subtract → state passes through EXEC for 1 cycle; result=0x1224; state_oh=10000.
- Bounce: toggle key_enter_n low/high with 3-cycle periods for 40 cycles, then hold high → no enter_p; a_reg unchanged.
- Press latency: a single clean press → enter_p exactly 6 cycles after the first low sample. A 200-cycle hold yields exactly one shift.
- Back/priority:
  - In S_B after one chunk, back and enter accepted in the same cycle → S_A with a_reg=b_reg=0.
  - In S_SHOW, back → S_OP with A/B retained. Loading op=0 gives result=0x1244.
- Reset mid-op: assert reset in the S_EXEC cycle → result stays 0 and state is S_A.
